ff_scanout: RTL and testbench
=============================

FF_SCANOUT -- requirements
Module: ff_scanout

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of captured flop bits (WIDTH >= 1).
REQ-002 SHALL have port C  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port R  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port snap_req  input  1  request to capture pin and start unloading.
REQ-005 SHALL have port pin  input  WIDTH  parallel flop outputs to be read back.
REQ-006 SHALL have port snap_busy  output  1  capture/unload in progress.
REQ-007 SHALL have port sout  output  1  serial data bit, LSB first.
REQ-008 SHALL have port sout_valid  output  1  sout holds a valid bit.
REQ-009 SHALL have port sout_ready  input  1  consumer accepts the bit.
REQ-010 SHALL have port sout_last  output  1  current bit is the final beat.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 In IDLE with snap_req=1 at edge k, SHALL load pin into a shadow register, clear the beat counter and enter SHIFT; sout_valid=1 and sout=pin[0] from edge k.
REQ-014 In SHIFT, SHALL advance one beat (shadow shifts right, counter +1) only on an edge where sout_valid and sout_ready are both 1.
REQ-015 SHALL hold sout and sout_last stable while sout_valid=1 and sout_ready=0.
REQ-016 SHALL assert sout_last when the counter equals the final beat index (WIDTH-1 without parity).
REQ-017 On acceptance of the last beat SHALL enter DONE, deassert sout_valid, and assert done for exactly one cycle, then return to IDLE.
REQ-018 snap_busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-019 snap_req while snap_busy=1 SHALL be ignored and not queued; snap_req in the cycle done=1 is ignored.
REQ-020 Changes on pin after the capture edge SHALL NOT affect the beats being unloaded.
REQ-021 For WIDTH=1, the first beat SHALL also carry sout_last=1.
REQ-022 Counter width SHALL be clog2(WIDTH+1) so the final index never wraps.

Reset
REQ-023 With R=1 at an edge, state SHALL become IDLE and shadow, counter, sout, sout_valid, sout_last, snap_busy and done SHALL all be 0, including mid-unload.
REQ-024 R=1 SHALL take priority over snap_req and any handshake in the same cycle.

Configuration
REQ-025 Macro FF_SCANOUT_PARITY_EN defined: SHALL append one extra beat after bit WIDTH-1 carrying the even parity (XOR) of the captured vector; sout_last moves to that beat (index WIDTH).
REQ-026 Macro FF_SCANOUT_PARITY_EN undefined: SHALL emit exactly WIDTH beats, no parity logic present.

Structure
REQ-027 Package ff_scanout_pkg SHALL hold the state enum type and the counter-width function.
REQ-028 Shadow load/shift SHALL be one sub-module ff_scanout_shreg (load, shift enable, serial out); FSM and counter stay in ff_scanout.

Verification (WIDTH=8 unless noted)
REQ-029 pin=8'hA5, sout_ready=1, snap_req pulse -> sout 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sout_last on 8th, done pulse next cycle, snap_busy 0 after.
REQ-030 pin=8'h3C, sout_ready low 3 cycles after beat 2 -> sout=1 held stable those 3 cycles, total sequence 0,0,1,1,1,1,0,0 intact.
REQ-031 snap_req re-asserted and pin changed to 8'hFF during unload of 8'h01 -> stream remains 1,0,0,0,0,0,0,0, no second unload starts.
REQ-032 R=1 after beat 4 -> next edge all outputs 0, IDLE; new snap_req with pin=8'h0F unloads cleanly from bit 0.
REQ-033 FF_SCANOUT_PARITY_EN, pin=8'hA5 -> 9 beats, 9th=0 with sout_last; pin=8'h07 -> 9th=1.
REQ-034 WIDTH=1, pin=1 -> single beat sout=1 with sout_last=1, done next cycle.

Source files
------------

// File: rtl/ff_scanout_pkg.sv
// Shared types and helpers for the flop scan-out unloader.
// FF_SCANOUT_PARITY_EN appends an even-parity beat after the data bits.
package ff_scanout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must reach the parity index WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

`ifdef FF_SCANOUT_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif

endpackage

// File: rtl/ff_scanout_shreg.sv
// Shadow register: parallel load, shift right with zero fill, LSB is the serial bit.
module ff_scanout_shreg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] load_data,
  output logic         sout
);

  logic [N-1:0] shadow_reg;
  logic [N-1:0] shadow_next;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      if (gi == N - 1) begin : g_top
        assign shadow_next[gi] = load  ? load_data[gi] :
                                 shift ? 1'b0 : shadow_reg[gi];
      end else begin : g_mid
        assign shadow_next[gi] = load  ? load_data[gi] :
                                 shift ? shadow_reg[gi+1] : shadow_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      shadow_reg <= '0;
    end else begin
      shadow_reg <= shadow_next;
    end
  end

  assign sout = shadow_reg[0];

endmodule

// File: rtl/ff_scanout.sv
// Captures a parallel flop vector and unloads it LSB first over a valid/ready stream.
// Optional FF_SCANOUT_PARITY_EN adds a final even-parity beat.
module ff_scanout
  import ff_scanout_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             C,
  input  logic             R,
  input  logic             snap_req,
  input  logic [WIDTH-1:0] pin,
  output logic             snap_busy,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             done
);

  localparam int SW = WIDTH + PAR_BEATS;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(SW - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SW-1:0]   load_data;
  logic            load;
  logic            accept;
  logic            at_last;
  logic            shreg_sout;

`ifdef FF_SCANOUT_PARITY_EN
  assign load_data = {^pin, pin};
`else
  assign load_data = pin;
`endif

  assign at_last = (cnt_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (snap_req) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          accept = 1'b1;
          if (at_last) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      DONE: begin
        // Requests arriving here are dropped on purpose, not queued.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  ff_scanout_shreg #(
    .N(SW)
  ) u_shreg (
    .clk      (C),
    .srst     (R),
    .load     (load),
    .shift    (accept),
    .load_data(load_data),
    .sout     (shreg_sout)
  );

  assign sout_valid = (state_reg == SHIFT);
  assign sout_last  = sout_valid && at_last;
  assign sout       = shreg_sout & sout_valid;
  assign done       = (state_reg == DONE);
  assign snap_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ff_scanout.sv
// Directed bench for ff_scanout (WIDTH=8 and WIDTH=1 instances).
// Build with FF_SCANOUT_PARITY_EN defined to exercise the parity beat.
module tb_ff_scanout;

`ifdef FF_SCANOUT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;

  logic       C = 1'b0;
  logic       R;
  logic       snap_req;
  logic [7:0] pin;
  logic       snap_busy, sout, sout_valid, sout_last, done;
  logic       sout_ready;

  logic       snap_req1;
  logic [0:0] pin1;
  logic       snap_busy1, sout1, sout_valid1, sout_last1, done1;
  logic       sout_ready1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 C = ~C;

  ff_scanout #(.WIDTH(8)) dut (
    .C(C), .R(R), .snap_req(snap_req), .pin(pin),
    .snap_busy(snap_busy), .sout(sout), .sout_valid(sout_valid),
    .sout_ready(sout_ready), .sout_last(sout_last), .done(done)
  );

  ff_scanout #(.WIDTH(1)) dut1 (
    .C(C), .R(R), .snap_req(snap_req1), .pin(pin1),
    .snap_busy(snap_busy1), .sout(sout1), .sout_valid(sout_valid1),
    .sout_ready(sout_ready1), .sout_last(sout_last1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  32'(snap_busy),  32'd0);
    check({tag, " valid"}, 32'(sout_valid), 32'd0);
    check({tag, " sout"},  32'(sout),       32'd0);
    check({tag, " last"},  32'(sout_last),  32'd0);
    check({tag, " done"},  32'(done),       32'd0);
  endtask

  // Full unload; exp_bits holds hand-computed beats {parity, data}.
  task automatic unload(input string name, input logic [7:0] pv, input logic [8:0] exp_bits,
                        input int stall_beat, input int stall_len, input bit pollute);
    pin        = pv;
    snap_req   = 1'b1;
    sout_ready = 1'b1;
    step();
    snap_req = 1'b0;
    if (pollute) begin
      snap_req = 1'b1;
      pin      = 8'hFF;
    end
    for (int b = 0; b < NB; b++) begin
      check($sformatf("%s b%0d valid", name, b), 32'(sout_valid), 32'd1);
      check($sformatf("%s b%0d sout", name, b),  32'(sout),       32'(exp_bits[b]));
      check($sformatf("%s b%0d last", name, b),  32'(sout_last),  32'(b == NB - 1));
      check($sformatf("%s b%0d busy", name, b),  32'(snap_busy),  32'd1);
      if (b == stall_beat) begin
        sout_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          check($sformatf("%s stall%0d sout", name, k),  32'(sout),       32'(exp_bits[b]));
          check($sformatf("%s stall%0d valid", name, k), 32'(sout_valid), 32'd1);
          check($sformatf("%s stall%0d last", name, k),  32'(sout_last),  32'(b == NB - 1));
        end
        sout_ready = 1'b1;
      end
      step();
    end
    check({name, " done"},       32'(done),       32'd1);
    check({name, " done valid"}, 32'(sout_valid), 32'd0);
    check({name, " done busy"},  32'(snap_busy),  32'd1);
    step();
    snap_req = 1'b0;
    check({name, " after done"}, 32'(done),      32'd0);
    check({name, " after busy"}, 32'(snap_busy), 32'd0);
    step();
    check({name, " no restart"}, 32'(snap_busy), 32'd0);
    $display("txn %s pin=%02h beats=%0d", name, pv, NB);
  endtask

  initial begin
    R = 1'b1; snap_req = 1'b0; pin = 8'h00; sout_ready = 1'b0;
    snap_req1 = 1'b0; pin1 = 1'b0; sout_ready1 = 1'b0;
    step();
    step();
    check_idle("reset");
    R = 1'b0;
    step();
    check_idle("post reset");

    // A5 = 1,0,1,0,0,1,0,1 LSB first; parity 0
    unload("a5", 8'hA5, {1'b0, 8'hA5}, -1, 0, 1'b0);
    // 3C = 0,0,1,1,1,1,0,0; hold beat 2 for 3 cycles; parity 0
    unload("3c_stall", 8'h3C, {1'b0, 8'h3C}, 2, 3, 1'b0);
    // 01 with pin=FF and snap_req held during unload; parity 1
    unload("01_pollute", 8'h01, {1'b1, 8'h01}, -1, 0, 1'b1);
    // 07 parity 1
    unload("07", 8'h07, {1'b1, 8'h07}, -1, 0, 1'b0);

    // Reset mid-unload after 4 accepted beats, with request and ready also high
    pin = 8'hA5; snap_req = 1'b1; sout_ready = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid b4 sout",  32'(sout),       32'd0);
    check("mid b4 valid", 32'(sout_valid), 32'd1);
    R = 1'b1; snap_req = 1'b1;
    step();
    check_idle("mid reset");
    R = 1'b0; snap_req = 1'b0;
    step();
    check_idle("mid reset idle");
    $display("txn mid_reset pin=a5 beats=4");
    // 0F = 1,1,1,1,0,0,0,0; parity 0
    unload("0f", 8'h0F, {1'b0, 8'h0F}, -1, 0, 1'b0);

    // WIDTH=1 instance
    pin1 = 1'b1; snap_req1 = 1'b1; sout_ready1 = 1'b1;
    step();
    snap_req1 = 1'b0;
    check("w1 b0 valid", 32'(sout_valid1), 32'd1);
    check("w1 b0 sout",  32'(sout1),       32'd1);
    check("w1 b0 last",  32'(sout_last1),  32'(PAR == 0));
    if (PAR == 1) begin
      step();
      check("w1 par sout", 32'(sout1),      32'd1);
      check("w1 par last", 32'(sout_last1), 32'd1);
    end
    step();
    check("w1 done",  32'(done1),       32'd1);
    check("w1 valid", 32'(sout_valid1), 32'd0);
    step();
    check("w1 idle done", 32'(done1),      32'd0);
    check("w1 idle busy", 32'(snap_busy1), 32'd0);
    $display("txn w1 pin=1 beats=%0d", 1 + PAR);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
